lb_trace_comparator: RTL and testbench

- Downstream consumer of the load-buffer (lb_table) observation ports of two lock-stepped Sodor5 copies in the security BMC/simulation harness.
- Turns each copy's lb_table valid/addr/data stream into an ordered event trace, buffers each trace in a small FIFO, and compares the two traces in order.
- Tolerates bounded timing skew between the copies; flags address/data divergence, excessive skew and buffer overflow as one sticky verdict.
- A harness asserts !diverge at its check cycle.

---
 rtl/lb_trace_comparator.sv | 215 +++++++++++++++++++++
 tb/tb_lb_trace_comparator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_trace_comparator.sv
// lb_trace_comparator: turns two lb_table observation streams into per-copy event FIFOs
// and compares them pairwise in order, tolerating bounded skew; the verdict is sticky.

module lb_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          wr_en, rd_en;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign rd_en = pop_i & ~empty_o;
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en && !rd_en)      level_d = level_q + (PW+1)'(1);
    else if (!wr_en && rd_en) level_d = level_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// state    | meaning
// IDLE     | after reset, waiting for the first enabled cycle
// RUN      | capturing, draining and comparing both traces
// DIVERGED | verdict latched; FIFOs and counters frozen until reset
module lb_trace_comparator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8,
  parameter int AW      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   cmp_data,
  input  logic                   valid1,
  input  logic [AW-1:0]          addr1,
  input  logic [AW-1:0]          data1,
  input  logic                   valid2,
  input  logic [AW-1:0]          addr2,
  input  logic [AW-1:0]          data2,
  output logic                   diverge,
  output logic [1:0]             cause,
  output logic [AW-1:0]          div_addr1,
  output logic [AW-1:0]          div_addr2,
  output logic [7:0]             match_count,
  output logic [$clog2(DEPTH):0] level1,
  output logic [$clog2(DEPTH):0] level2
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DIVERGED = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_MISMATCH = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_OVERFLOW = 2'd3;

  state_t          state_q, state_d;
  logic            vq1_q, vq2_q;
  logic [AW-1:0]   aq1_q, aq2_q;
  logic [7:0]      age_q, age_d, age_inc;
  logic            diverge_q, diverge_d;
  logic [1:0]      cause_q, cause_d;
  logic [AW-1:0]   div_addr1_q, div_addr1_d, div_addr2_q, div_addr2_d;
  logic [7:0]      match_q, match_d;

  logic            evt1, evt2, push1, push2, pop;
  logic            full1, full2, empty1, empty2;
  logic [2*AW-1:0] head1, head2;
  logic            mismatch, ovf, tmo, raise, one_waiting;

  // A new event is a valid edge or an address change while valid stays high.
  assign evt1  = en & valid1 & (~vq1_q | (addr1 != aq1_q));
  assign evt2  = en & valid2 & (~vq2_q | (addr2 != aq2_q));
  assign push1 = evt1 & (state_q != DIVERGED);
  assign push2 = evt2 & (state_q != DIVERGED);
  assign pop   = (state_q == RUN) & ~empty1 & ~empty2;

  lb_trace_fifo #(.DEPTH(DEPTH), .W(2*AW)) u_fifo1 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push1),
    .pop_i   (pop),
    .wdata_i ({addr1, data1}),
    .rdata_o (head1),
    .level_o (level1),
    .full_o  (full1),
    .empty_o (empty1)
  );

  lb_trace_fifo #(.DEPTH(DEPTH), .W(2*AW)) u_fifo2 (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push2),
    .pop_i   (pop),
    .wdata_i ({addr2, data2}),
    .rdata_o (head2),
    .level_o (level2),
    .full_o  (full2),
    .empty_o (empty2)
  );

  assign mismatch    = pop & ((head1[2*AW-1:AW] != head2[2*AW-1:AW]) |
                              (cmp_data & (head1[AW-1:0] != head2[AW-1:0])));
  assign ovf         = ~pop & ((push1 & full1) | (push2 & full2));
  assign one_waiting = empty1 ^ empty2;
  assign age_inc     = age_q + 8'd1;
  assign tmo         = (state_q == RUN) & one_waiting & (age_inc == 8'(TIMEOUT));
  assign raise       = mismatch | ovf | tmo;

  always_comb begin
    state_d     = state_q;
    age_d       = age_q;
    diverge_d   = diverge_q;
    cause_d     = cause_q;
    div_addr1_d = div_addr1_q;
    div_addr2_d = div_addr2_q;
    match_d     = match_q;
    case (state_q)
      IDLE: begin
        age_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        age_d = (pop || !one_waiting) ? 8'd0 : age_inc;
        if (pop && !mismatch && match_q != 8'hFF) match_d = match_q + 8'd1;
        if (raise) begin
          state_d     = DIVERGED;
          diverge_d   = 1'b1;
          cause_d     = mismatch ? CAUSE_MISMATCH : (ovf ? CAUSE_OVERFLOW : CAUSE_TIMEOUT);
          div_addr1_d = empty1 ? '0 : head1[2*AW-1:AW];
          div_addr2_d = empty2 ? '0 : head2[2*AW-1:AW];
        end
      end
      DIVERGED: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vq1_q       <= 1'b0;
      vq2_q       <= 1'b0;
      aq1_q       <= '0;
      aq2_q       <= '0;
      age_q       <= '0;
      diverge_q   <= 1'b0;
      cause_q     <= '0;
      div_addr1_q <= '0;
      div_addr2_q <= '0;
      match_q     <= '0;
    end else begin
      state_q     <= state_d;
      vq1_q       <= valid1;
      vq2_q       <= valid2;
      aq1_q       <= addr1;
      aq2_q       <= addr2;
      age_q       <= age_d;
      diverge_q   <= diverge_d;
      cause_q     <= cause_d;
      div_addr1_q <= div_addr1_d;
      div_addr2_q <= div_addr2_d;
      match_q     <= match_d;
    end
  end

  assign diverge     = diverge_q;
  assign cause       = cause_q;
  assign div_addr1   = div_addr1_q;
  assign div_addr2   = div_addr2_q;
  assign match_count = match_q;
endmodule

// File: tb/tb_lb_trace_comparator.sv
// Bench for lb_trace_comparator: queue-based trace model checked every cycle, plus
// directed scenarios with hand-computed expectations.

module tb_lb_trace_comparator;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int AW      = 32;

  logic          clk = 1'b0;
  logic          reset, en, cmp_data;
  logic          valid1, valid2;
  logic [AW-1:0] addr1, data1, addr2, data2;
  logic          diverge;
  logic [1:0]    cause;
  logic [AW-1:0] div_addr1, div_addr2;
  logic [7:0]    match_count;
  logic [2:0]    level1, level2;

  int checks = 0;
  int failures = 0;

  lb_trace_comparator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .en(en), .cmp_data(cmp_data),
    .valid1(valid1), .addr1(addr1), .data1(data1),
    .valid2(valid2), .addr2(addr2), .data2(data2),
    .diverge(diverge), .cause(cause), .div_addr1(div_addr1), .div_addr2(div_addr2),
    .match_count(match_count), .level1(level1), .level2(level2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two event queues, a skew age, and the sticky verdict.
  logic [31:0] q1a[$], q1d[$], q2a[$], q2d[$];
  int          m_st, m_age, m_mc, m_cause;
  logic        m_div, m_vq1, m_vq2;
  logic [31:0] m_aq1, m_aq2, m_da1, m_da2;

  always @(posedge clk) begin
    bit          e1, e2, pop, mis, waiting, tmo, ovf;
    logic [31:0] h1, h2;
    int          na;
    if (reset) begin
      q1a.delete(); q1d.delete(); q2a.delete(); q2d.delete();
      m_st = 0; m_age = 0; m_mc = 0; m_cause = 0; m_div = 0;
      m_vq1 = 0; m_vq2 = 0; m_aq1 = 0; m_aq2 = 0; m_da1 = 0; m_da2 = 0;
    end else begin
      e1 = en && valid1 && (!m_vq1 || addr1 != m_aq1);
      e2 = en && valid2 && (!m_vq2 || addr2 != m_aq2);
      m_vq1 = valid1; m_aq1 = addr1; m_vq2 = valid2; m_aq2 = addr2;
      if (m_st != 2) begin
        pop = (m_st == 1) && q1a.size() > 0 && q2a.size() > 0;
        h1 = (q1a.size() > 0) ? q1a[0] : 32'h0;
        h2 = (q2a.size() > 0) ? q2a[0] : 32'h0;
        mis = pop && (q1a[0] != q2a[0] || (cmp_data && q1d[0] != q2d[0]));
        waiting = (m_st == 1) && ((q1a.size() == 0) != (q2a.size() == 0));
        na = waiting ? m_age + 1 : 0;
        tmo = waiting && na == TIMEOUT;
        ovf = !pop && ((e1 && q1a.size() == DEPTH) || (e2 && q2a.size() == DEPTH));
        if (pop) begin
          void'(q1a.pop_front()); void'(q1d.pop_front());
          void'(q2a.pop_front()); void'(q2d.pop_front());
          if (!mis && m_mc < 255) m_mc++;
        end
        if (e1 && q1a.size() < DEPTH) begin q1a.push_back(addr1); q1d.push_back(data1); end
        if (e2 && q2a.size() < DEPTH) begin q2a.push_back(addr2); q2d.push_back(data2); end
        m_age = na;
        if (mis || ovf || tmo) begin
          m_st = 2; m_div = 1;
          m_cause = mis ? 1 : (ovf ? 3 : 2);
          m_da1 = h1; m_da2 = h2;
        end else if (m_st == 0 && en) begin
          m_st = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_diverge", diverge, m_div);
    chk("model_cause", cause, m_cause);
    chk("model_div_addr1", div_addr1, m_da1);
    chk("model_div_addr2", div_addr2, m_da2);
    chk("model_match_count", match_count, m_mc);
    chk("model_level1", level1, q1a.size());
    chk("model_level2", level2, q2a.size());
  end

  task automatic cyc(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic v2, input logic [31:0] a2, input logic [31:0] d2);
    valid1 = v1; addr1 = a1; data1 = d1;
    valid2 = v2; addr2 = a2; data2 = d2;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en = 1'b0; cmp_data = 1'b0;
    do_reset();
    chk("reset_diverge", diverge, 0);
    chk("reset_match", match_count, 0);
    chk("reset_level1", level1, 0);

    // en=0 gates capture entirely
    cyc(1, 32'h64, 0, 1, 32'h64, 0);
    idle(2);
    chk("en0_level1", level1, 0);
    chk("en0_match", match_count, 0);

    // identical streams
    do_reset(); en = 1'b1;
    cyc(1, 32'h64, 0, 1, 32'h64, 0);
    cyc(1, 32'h68, 0, 1, 32'h68, 0);
    idle(3);
    chk("same_match", match_count, 2);
    chk("same_diverge", diverge, 0);
    chk("same_level1", level1, 0);
    chk("same_level2", level2, 0);

    // address mismatch, two-cycle latency
    do_reset();
    cyc(1, 32'h64, 0, 1, 32'h68, 0);
    chk("mis_t1_diverge", diverge, 0);
    idle(1);
    chk("mis_t2_diverge", diverge, 1);
    chk("mis_cause", cause, 1);
    chk("mis_div_addr1", div_addr1, 32'h64);
    chk("mis_div_addr2", div_addr2, 32'h68);
    cyc(1, 32'h80, 0, 1, 32'h80, 0);
    idle(1);
    chk("mis_frozen_level1", level1, 0);
    chk("mis_frozen_match", match_count, 0);

    // skew of 3 cycles
    do_reset();
    cyc(1, 32'h64, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 32'h64, 0);
    idle(3);
    chk("skew3_match", match_count, 1);
    chk("skew3_diverge", diverge, 0);

    // skew of TIMEOUT-1 cycles is still tolerated
    do_reset();
    cyc(1, 32'h64, 0, 0, 0, 0);
    idle(TIMEOUT - 2);
    cyc(0, 0, 0, 1, 32'h64, 0);
    idle(3);
    chk("skew7_match", match_count, 1);
    chk("skew7_diverge", diverge, 0);

    // copy 2 silent -> timeout
    do_reset();
    cyc(1, 32'h70, 0, 0, 0, 0);
    idle(TIMEOUT - 1);
    chk("tmo_early_diverge", diverge, 0);
    idle(1);
    chk("tmo_diverge", diverge, 1);
    chk("tmo_cause", cause, 2);
    chk("tmo_div_addr1", div_addr1, 32'h70);
    chk("tmo_div_addr2", div_addr2, 0);
    chk("tmo_level1", level1, 1);

    // overflow on the fifth push
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 32'h10 + 32'(4 * i), 32'(i), 0, 0, 0);
      if (i == 3) begin
        chk("ovf_pre_level1", level1, 4);
        chk("ovf_pre_diverge", diverge, 0);
      end
    end
    chk("ovf_diverge", diverge, 1);
    chk("ovf_cause", cause, 3);
    chk("ovf_level1", level1, 4);
    chk("ovf_div_addr1", div_addr1, 32'h10);
    chk("ovf_div_addr2", div_addr2, 0);
    cyc(1, 32'h40, 0, 1, 32'h44, 0);
    idle(1);
    chk("ovf_frozen_level1", level1, 4);
    chk("ovf_frozen_level2", level2, 0);

    // reset out of DIVERGED, then a clean stream
    do_reset();
    chk("rst_div_diverge", diverge, 0);
    chk("rst_div_cause", cause, 0);
    chk("rst_div_addr1", div_addr1, 0);
    chk("rst_div_addr2", div_addr2, 0);
    chk("rst_div_level1", level1, 0);
    cyc(1, 32'h64, 0, 1, 32'h64, 0);
    idle(2);
    chk("post_rst_match", match_count, 1);
    chk("post_rst_diverge", diverge, 0);

    // data comparison enable
    do_reset(); cmp_data = 1'b0;
    cyc(1, 32'h64, 32'h1, 1, 32'h64, 32'h2);
    idle(2);
    chk("data_off_match", match_count, 1);
    chk("data_off_diverge", diverge, 0);
    do_reset(); cmp_data = 1'b1;
    cyc(1, 32'h64, 32'h1, 1, 32'h64, 32'h2);
    idle(1);
    chk("data_on_diverge", diverge, 1);
    chk("data_on_cause", cause, 1);
    cmp_data = 1'b0;

    // en dropped in RUN: pending entries still drain, timeout still runs
    do_reset(); en = 1'b1;
    cyc(1, 32'h64, 0, 1, 32'h64, 0);
    en = 1'b0;
    idle(2);
    chk("en_drop_match", match_count, 1);
    chk("en_drop_level1", level1, 0);
    do_reset(); en = 1'b1;
    cyc(1, 32'h90, 0, 0, 0, 0);
    en = 1'b0;
    cyc(0, 0, 0, 1, 32'h90, 0);
    idle(TIMEOUT - 1);
    chk("en_drop_tmo_diverge", diverge, 1);
    chk("en_drop_tmo_cause", cause, 2);

    // match_count saturation
    do_reset(); en = 1'b1;
    for (int i = 0; i < 260; i++) cyc(1, 32'(4 * i), 0, 1, 32'(4 * i), 0);
    idle(2);
    chk("sat_match", match_count, 255);
    chk("sat_diverge", diverge, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
